// File: rtl/gcn_aggregation_fsm.sv
// gcn_aggregation_fsm
// Aggregation engine for the GCN accelerator. For every node it loads that
// node's own product row into an accumulator, then walks the COO edge list
// and, for each valid undirected edge (src, dst), adds product row src into
// acc[dst] and product row dst into acc[src]. A self-loop is added only once.
// Edges that name a node outside the graph set a sticky err flag and are
// skipped. Results are held in the accumulators after done rises.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   start            begin a run (sampled only in IDLE and DONE)
//   prod_rd_en/addr  product-memory read strobe and row address
//   prod_rd_data     product row, column c at [c*DATA_WIDTH +: DATA_WIDTH],
//                    valid one cycle after the strobe
//   edge_rd_en/addr  edge-memory read strobe and edge index
//   edge_rd_data     {dst, src}, valid one cycle after the strobe
//   out_rd_addr      result row select
//   out_rd_data      combinational accumulator row, packed like the product
//   err              sticky: an edge referenced a node >= FEATURE_ROWS
//   done             run complete, results valid
module gcn_aggregation_fsm #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int NUM_EDGES       = 6,
    parameter int DATA_WIDTH      = 16,
    parameter int ACC_WIDTH       = 20,
    parameter int ROW_ADDR_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int EDGE_ADDR_WIDTH = $clog2(NUM_EDGES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               prod_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]          prod_rd_addr,
    input  logic [WEIGHT_COLS*DATA_WIDTH-1:0]  prod_rd_data,
    output logic                               edge_rd_en,
    output logic [EDGE_ADDR_WIDTH-1:0]         edge_rd_addr,
    input  logic [2*ROW_ADDR_WIDTH-1:0]        edge_rd_data,
    input  logic [ROW_ADDR_WIDTH-1:0]          out_rd_addr,
    output logic [WEIGHT_COLS*ACC_WIDTH-1:0]   out_rd_data,
    output logic                               err,
    output logic                               done
);

    typedef enum logic [3:0] {
        IDLE, SELF_ADDR, SELF_LOAD, EDGE_ADDR, EDGE_LATCH,
        SRC_ADDR, SRC_ACC, DST_ADDR, DST_ACC, DONE
    } state_t;

    state_t state, next_state;

    logic [ROW_ADDR_WIDTH-1:0]  row_cnt;
    logic [EDGE_ADDR_WIDTH-1:0] edge_cnt;
    logic [ROW_ADDR_WIDTH-1:0]  src, dst;
    logic [ACC_WIDTH-1:0]       acc [FEATURE_ROWS][WEIGHT_COLS];

    logic [ROW_ADDR_WIDTH-1:0]  edge_src, edge_dst;
    logic                       edge_bad;
    logic                       last_row, last_edge;

    assign edge_src  = edge_rd_data[ROW_ADDR_WIDTH-1:0];
    assign edge_dst  = edge_rd_data[2*ROW_ADDR_WIDTH-1:ROW_ADDR_WIDTH];
    assign edge_bad  = (32'(edge_src) >= 32'(FEATURE_ROWS)) ||
                       (32'(edge_dst) >= 32'(FEATURE_ROWS));
    assign last_row  = (row_cnt == ROW_ADDR_WIDTH'(FEATURE_ROWS - 1));
    assign last_edge = (edge_cnt == EDGE_ADDR_WIDTH'(NUM_EDGES - 1));

    function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] d);
        return ACC_WIDTH'($signed(d));
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        prod_rd_en   = 1'b0;
        prod_rd_addr = '0;
        edge_rd_en   = 1'b0;
        edge_rd_addr = '0;
        done         = 1'b0;
        case (state)
            IDLE:       if (start) next_state = SELF_ADDR;
            SELF_ADDR: begin
                prod_rd_en   = 1'b1;
                prod_rd_addr = row_cnt;
                next_state   = SELF_LOAD;
            end
            SELF_LOAD:  next_state = last_row ? EDGE_ADDR : SELF_ADDR;
            EDGE_ADDR: begin
                edge_rd_en   = 1'b1;
                edge_rd_addr = edge_cnt;
                next_state   = EDGE_LATCH;
            end
            EDGE_LATCH: begin
                if (edge_bad) next_state = last_edge ? DONE : EDGE_ADDR;
                else          next_state = SRC_ADDR;
            end
            SRC_ADDR: begin
                prod_rd_en   = 1'b1;
                prod_rd_addr = src;
                next_state   = SRC_ACC;
            end
            SRC_ACC: begin
                if (src == dst) next_state = last_edge ? DONE : EDGE_ADDR;
                else            next_state = DST_ADDR;
            end
            DST_ADDR: begin
                prod_rd_en   = 1'b1;
                prod_rd_addr = dst;
                next_state   = DST_ACC;
            end
            DST_ACC:    next_state = last_edge ? DONE : EDGE_ADDR;
            DONE: begin
                done = 1'b1;
                if (start) next_state = SELF_ADDR;
            end
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt  <= '0;
            edge_cnt <= '0;
            src      <= '0;
            dst      <= '0;
            err      <= 1'b0;
            for (int unsigned r = 0; r < FEATURE_ROWS; r++)
                for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                    acc[r][c] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        row_cnt  <= '0;
                        edge_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                SELF_LOAD: begin
                    for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                        acc[row_cnt][c] <= sext(prod_rd_data[c*DATA_WIDTH +: DATA_WIDTH]);
                    if (!last_row) row_cnt <= row_cnt + 1'b1;
                end
                EDGE_LATCH: begin
                    src <= edge_src;
                    dst <= edge_dst;
                    if (edge_bad) begin
                        err <= 1'b1;
                        if (!last_edge) edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                SRC_ACC: begin
                    // row src is on the bus: it belongs to dst's neighbourhood
                    for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                        acc[dst][c] <= acc[dst][c] + sext(prod_rd_data[c*DATA_WIDTH +: DATA_WIDTH]);
                    if (src == dst && !last_edge) edge_cnt <= edge_cnt + 1'b1;
                end
                DST_ACC: begin
                    for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                        acc[src][c] <= acc[src][c] + sext(prod_rd_data[c*DATA_WIDTH +: DATA_WIDTH]);
                    if (!last_edge) edge_cnt <= edge_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_rd_data = '0;
        for (int unsigned r = 0; r < FEATURE_ROWS; r++)
            if (out_rd_addr == ROW_ADDR_WIDTH'(r))
                for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                    out_rd_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
    end

endmodule

// File: tb/tb_gcn_aggregation_fsm.sv
// Testbench for gcn_aggregation_fsm: memories modelled in the bench, each run's
// expected results computed from the aggregation rules and queued at start;
// a monitor pops and compares whenever done rises.
module tb_gcn_aggregation_fsm;
    localparam int FR  = 6;
    localparam int WC  = 3;
    localparam int NE  = 6;
    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int RAW = 3;
    localparam int EAW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 prod_rd_en;
    logic [RAW-1:0]       prod_rd_addr;
    logic [WC*DW-1:0]     prod_rd_data;
    logic                 edge_rd_en;
    logic [EAW-1:0]       edge_rd_addr;
    logic [2*RAW-1:0]     edge_rd_data;
    logic [RAW-1:0]       out_rd_addr;
    logic [WC*AW-1:0]     out_rd_data;
    logic                 err;
    logic                 done;

    gcn_aggregation_fsm #(
        .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .NUM_EDGES(NE),
        .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .ROW_ADDR_WIDTH(RAW), .EDGE_ADDR_WIDTH(EAW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .prod_rd_en(prod_rd_en), .prod_rd_addr(prod_rd_addr), .prod_rd_data(prod_rd_data),
        .edge_rd_en(edge_rd_en), .edge_rd_addr(edge_rd_addr), .edge_rd_data(edge_rd_data),
        .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
        .err(err), .done(done)
    );

    always #5 clk = ~clk;

    // External memories with one-cycle read latency
    logic [WC*DW-1:0] prod_mem [FR];
    logic [2*RAW-1:0] edge_mem [NE];
    always @(posedge clk) begin
        if (prod_rd_en) prod_rd_data <= prod_mem[prod_rd_addr];
        if (edge_rd_en) edge_rd_data <= edge_mem[edge_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result row select shared between monitor and stimulus
    logic           mon_busy = 1'b0;
    logic [RAW-1:0] mon_addr = '0;
    logic [RAW-1:0] stim_addr = '0;
    assign out_rd_addr = mon_busy ? mon_addr : stim_addr;

    typedef struct packed {
        logic [FR*WC*AW-1:0] rows;
        logic                err;
        int                  cycles;
        int                  start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   issued  = 0;
    int   checked = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: node n = own row + every valid neighbour's row, wrapped to AW bits
    function automatic exp_t model(input int start_cyc);
        exp_t        e;
        longint      sum [FR][WC];
        logic [63:0] tmp;
        int          s, d;
        e.rows      = '0;
        e.err       = 1'b0;
        e.cycles    = 2 * FR;
        e.start_cyc = start_cyc;
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++)
                sum[n][c] = $signed(prod_mem[n][c*DW +: DW]);
        for (int k = 0; k < NE; k++) begin
            s = int'(edge_mem[k][RAW-1:0]);
            d = int'(edge_mem[k][2*RAW-1:RAW]);
            if (s >= FR || d >= FR) begin
                e.err = 1'b1;
                e.cycles += 2;
            end else begin
                for (int c = 0; c < WC; c++) begin
                    sum[d][c] += $signed(prod_mem[s][c*DW +: DW]);
                    if (s != d) sum[s][c] += $signed(prod_mem[d][c*DW +: DW]);
                end
                e.cycles += (s == d) ? 4 : 6;
            end
        end
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++) begin
                tmp = sum[n][c];
                e.rows[(n*WC + c)*AW +: AW] = tmp[AW-1:0];
            end
        return e;
    endfunction

    // Monitor
    bit prev_done = 1'b0;
    initial begin
        exp_t        e;
        logic [63:0] want;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected no pending run");
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc - e.start_cyc - 1), 64'(e.cycles));
                    check("err", 64'(err), 64'(e.err));
                    mon_busy = 1'b1;
                    for (int r = 0; r < FR; r++) begin
                        mon_addr = RAW'(r);
                        #1;
                        want = 64'(e.rows[r*WC*AW +: WC*AW]);
                        check($sformatf("row%0d", r), 64'(out_rd_data), want);
                    end
                    mon_busy = 1'b0;
                    checked++;
                end
            end
            prev_done = done;
        end
    end

    task automatic run();
        bit was_done;
        @(negedge clk);
        was_done = done;
        exp_q.push_back(model(cyc));
        issued++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (was_done) check("done_drop", 64'(done), 64'd0);
        for (int i = 0; i < 300 && checked < issued; i++) @(negedge clk);
        if (checked < issued) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done within 300 cycles, expected done");
            exp_q.delete();
            checked = issued;
        end
    endtask

    task automatic set_prod_inc();
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++)
                prod_mem[r][c*DW +: DW] = DW'(r + 1);
    endtask

    task automatic set_edges(input int s, input int d);
        for (int k = 0; k < NE; k++) edge_mem[k] = {RAW'(d), RAW'(s)};
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_prod_en"}, 64'(prod_rd_en), 64'd0);
        check({tag, "_edge_en"}, 64'(edge_rd_en), 64'd0);
        check({tag, "_addrs"}, 64'({prod_rd_addr, edge_rd_addr}), 64'd0);
        for (int r = 0; r < FR; r++) begin
            stim_addr = RAW'(r);
            #1;
            check($sformatf("%s_row%0d", tag, r), 64'(out_rd_data), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int r = 0; r < FR; r++) prod_mem[r] = '0;
        set_edges(0, 1);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        // Neighbour pair repeated on every edge
        set_prod_inc();
        set_edges(0, 1);
        run();

        // Self-loops only
        set_edges(2, 2);
        run();

        // Negative data
        for (int r = 0; r < FR; r++) prod_mem[r] = '1;
        set_edges(0, 1);
        run();

        // Out-of-range source on the first edge
        set_prod_inc();
        set_edges(0, 1);
        edge_mem[0] = {RAW'(0), RAW'(7)};
        run();

        // Restart from DONE with new data clears err
        for (int r = 0; r < FR; r++) prod_mem[r] = (WC*DW)'({$urandom, $urandom});
        set_edges(0, 1);
        run();

        // Reset in the middle of a run
        set_prod_inc();
        set_edges(3, 4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        @(negedge clk);
        reset = 1'b0;
        run();

        // Randomised runs, occasional invalid indices and duplicates
        for (int t = 0; t < 20; t++) begin
            for (int r = 0; r < FR; r++) prod_mem[r] = (WC*DW)'({$urandom, $urandom});
            for (int k = 0; k < NE; k++) begin
                int s, d;
                s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
                d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
                if ($urandom_range(0, 5) == 0) d = s;
                edge_mem[k] = {RAW'(d), RAW'(s)};
            end
            run();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gcn_aggregation_fsm.md
# gcn_aggregation_fsm

Aggregation (combination) engine for the GCN accelerator; consumes the feature×weight product memory that the transformation stage fills. Walks the product memory and a COO edge list to accumulate, per node, its own product row plus the product rows of every neighbour (undirected edges). Results are held in internal accumulators and exposed through a combinational read port once `done` is high.

## Interface
- FEATURE_ROWS, 6, number of nodes (product rows)
- WEIGHT_COLS, 3, columns per product row
- NUM_EDGES, 6, COO edge-list entries processed per run
- DATA_WIDTH, 16, signed width of one product element
- ACC_WIDTH, 20, signed accumulator width (must be ≥ DATA_WIDTH)
- ROW_ADDR_WIDTH, $clog2(FEATURE_ROWS), node index width
- EDGE_ADDR_WIDTH, $clog2(NUM_EDGES), edge-memory address width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a run; sampled in IDLE and DONE
- prod_rd_en  out  1  product-memory read strobe
- prod_rd_addr  out  ROW_ADDR_WIDTH  product row address
- prod_rd_data  in  WEIGHT_COLS*DATA_WIDTH  row; column c at [c*DATA_WIDTH +: DATA_WIDTH]; valid one cycle after strobe
- edge_rd_en  out  1  edge-memory read strobe
- edge_rd_addr  out  EDGE_ADDR_WIDTH  edge index
- edge_rd_data  in  2*ROW_ADDR_WIDTH  src in low half, dst in high half; valid one cycle after strobe
- out_rd_addr  in  ROW_ADDR_WIDTH  result row select
- out_rd_data  out  WEIGHT_COLS*ACC_WIDTH  combinational acc row; column packing as product
- err  out  1  sticky: an edge had an index ≥ FEATURE_ROWS
- done  out  1  run complete, results valid

## Operation
- States: IDLE, SELF_ADDR, SELF_LOAD, EDGE_ADDR, EDGE_LATCH, SRC_ADDR, SRC_ACC, DST_ADDR, DST_ACC, DONE.
- IDLE: all strobes 0; start=1 → SELF_ADDR, row_cnt=0, edge_cnt=0, err cleared.
- SELF_ADDR: prod_rd_en=1, addr=row_cnt → SELF_LOAD.
- SELF_LOAD: acc[row_cnt][c] ← sign-extend(prod col c); row_cnt==FEATURE_ROWS-1 → EDGE_ADDR else row_cnt++ → SELF_ADDR.
- EDGE_ADDR: edge_rd_en=1, addr=edge_cnt → EDGE_LATCH.
- EDGE_LATCH: register src/dst. If either ≥ FEATURE_ROWS: err←1, edge skipped (goto edge-advance). Else → SRC_ADDR.
- SRC_ADDR: prod_rd_en=1, addr=src → SRC_ACC: acc[dst] += row. If src==dst → edge-advance (self-loop added once); else → DST_ADDR.
- DST_ADDR: prod_rd_en=1, addr=dst → DST_ACC: acc[src] += row → edge-advance.
- Edge-advance: edge_cnt==NUM_EDGES-1 → DONE, else edge_cnt++ → EDGE_ADDR.
- DONE: done=1, strobes 0, accumulators frozen; start=1 → SELF_ADDR (done drops next cycle, new run overwrites acc).
- Arithmetic: two's-complement, modulo 2^ACC_WIDTH wrap, no saturation, no overflow flag.
- Duplicate edges each accumulate independently.

## Timing
- Reset (async): state IDLE, all acc 0, counters 0, done=0, err=0, prod_rd_en=0, edge_rd_en=0, addresses 0. out_rd_data reflects zeroed acc.
- Reset mid-run: immediate abort to IDLE, partial results discarded.
- Memory read latency exactly 1 cycle; every *_ADDR state is followed by its consume state.
- Cycle budget from the edge sampling start: 2*FEATURE_ROWS + Σ per edge (6 normal, 4 self-loop, 2 invalid). Defaults, 6 distinct valid edges: DONE entered 48 cycles later, done high that cycle.
- Strobes are single-cycle per access; no back-pressure.
- start ignored outside IDLE/DONE.

## Test plan
- prod row r = all columns r+1; all 6 edges (0,1) → acc[0]=13, acc[1]=8, acc[r]=r+1 for r≥2; done 48 cycles after start; err=0.
- All edges (2,2) → acc[2]=3+6*3=21 in every column, others r+1; done after 12+24=36 cycles.
- prod all 0xFFFF (−1), all edges (0,1) → acc[0]=acc[1]=−7 (0xFFFF9), others 0xFFFFF.
- Edge 0 = (src 7, dst 0) with ROW_ADDR_WIDTH=3, rest (0,1) → err=1 sticky, edge 0 contributes nothing (acc[0]=1+5*2=11).
- Assert reset 10 cycles into a run → done=0, all out_rd_data 0, strobes 0 same cycle; fresh start completes normally.
- In DONE, pulse start with changed prod data → done drops, new results after another 48 cycles, err cleared.
